vga_sync_receiver: RTL and testbench
====================================

# vga_sync_receiver

Sink-side timing recovery for the VGA sync stream produced by the team's VGA sync generator (nominal 800x600@60, 40 MHz pixel clock). It samples hsync/vsync, measures line period and frame height, and locks after two identical full frames. Once locked it regenerates a pixel-valid strobe plus column/row addresses for downstream capture, checking or frame-grab logic. It runs on the same pixel clock as the source, so no synchronizer is used.

## Interface
- CNT_W, 11: width of horizontal/vertical counters and address outputs
- SYNC_POL, 0: active level of both sync inputs (0 = active-low)
- H_OFFSET, 216: clocks from hsync leading edge to first active pixel (sync 128 + back porch 88)
- H_ACTIVE, 800: active pixels per line
- V_OFFSET, 27: lines from vsync leading edge to first active line (sync 4 + back porch 23)
- V_ACTIVE, 600: active lines per frame

- clk  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- hsync_sig  in  1  horizontal sync from source
- vsync_sig  in  1  vertical sync from source
- locked  out  1  timing locked
- lock_lost  out  1  one-cycle pulse on LOCKED -> SEARCH
- ready  out  1  active pixel strobe (valid only when locked)
- column_addr_sig  out  CNT_W  active column, 0 when ready=0
- row_addr_sig  out  CNT_W  active row, 0 when ready=0
- line_len  out  CNT_W  last measured hsync period in clocks
- frame_lines  out  CNT_W  last measured frame height in lines

## Operation
- hs_d/vs_d: registered copies of the inputs. hs_lead = (hsync_sig==SYNC_POL) && (hs_d!=SYNC_POL); vs_lead is defined the same way. Both are combinational on the raw input.
- h_cnt: cleared on hs_lead, otherwise incremented. It saturates at 2^CNT_W-1.
- On hs_lead, when a prior hs_lead has been seen since reset, the period h_cnt+1 is compared with line_len. A mismatch sets h_err. line_len is then loaded with the new period.
- v_cnt: incremented on hs_lead and cleared on vs_lead. If both events occur in the same cycle, the clear wins (v_cnt=0), so row 0 of the sync region coincides with the first line.
- On vs_lead: new_lines = v_cnt + hs_lead is computed, frame_lines is loaded with new_lines, and frame_valid is set.
- FSM, reset state SEARCH:
  - SEARCH: on vs_lead, go to MEASURE. frame_valid and h_err are cleared.
  - MEASURE: on vs_lead, go to LOCKED if frame_valid && !h_err && new_lines==frame_lines (old value); otherwise stay. h_err is cleared on every vs_lead.
  - LOCKED: go to SEARCH on any h_err set, on vs_lead with new_lines!=frame_lines, or on h_cnt saturation (hsync loss). lock_lost pulses 1 cycle on this transition.
- Pixel generation, registered. The next-state value is ready = LOCKED && H_OFFSET <= h_cnt < H_OFFSET+H_ACTIVE && V_OFFSET <= v_cnt < V_OFFSET+V_ACTIVE. column_addr_sig = h_cnt-H_OFFSET and row_addr_sig = v_cnt-V_OFFSET when ready, else 0.
- Arithmetic: address subtraction is CNT_W-wide unsigned and is only taken when in range. The period compare is CNT_W-wide. A period of 2^CNT_W or more saturates and counts as loss.

## Timing
- Reset: locked, lock_lost, ready, column_addr_sig, row_addr_sig, line_len, frame_lines, h_cnt, v_cnt = 0. hs_d and vs_d are reset to the inactive level. FSM = SEARCH, h_err = frame_valid = 0.
- Reset asserted mid-frame: all state returns to the reset values on the next edge, and relock requires 3 vsync leading edges.
- Let edge k be the edge at which hsync_sig is first sampled active. Then h_cnt=n during cycle k+n, and ready/column_addr_sig reflect h_cnt=n in cycle k+n+1. Column 0 therefore appears H_OFFSET+1 cycles after edge k.
- locked rises in the cycle after the 3rd vs_lead following reset (1st: SEARCH->MEASURE, 2nd: first full-frame capture, 3rd: compare).
- Sync asserted continuously produces no leading edges and is treated as hsync loss via saturation.

## Test plan
- Nominal stream (line 1056 clk, hsync 128 low, 628 lines, vsync 4 lines low, edges aligned) → line_len=1056, frame_lines=628, locked=1 after 3rd vsync edge. Exactly 800 ready cycles per line, column 0..799, row 0..599, and 480000 ready cycles per frame.
- Locked, one line lengthened to 1057 → lock_lost pulse at that hsync edge, locked=0, ready=0. Relock occurs after 3 further vsync edges.
- Locked, one frame with 627 lines → lock_lost at that vsync edge with frame_lines=627. Relock follows after two 628-line frames.
- Locked, hsync held inactive → lock_lost when h_cnt reaches 2047. All address outputs are 0.
- rst_n low for 1 cycle mid-line while locked → all outputs 0 on the next edge, FSM=SEARCH, no lock_lost pulse.
- Coincident hsync/vsync edges vs vsync edge 5 clocks after hsync → row 0 starts at the correct line in both cases, with v_cnt=0 on the coincident edge.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// VGA sync stream receiver: measures line period and frame height, locks after two
// identical full frames, then regenerates the active-pixel strobe and column/row addresses.
module vga_sync_receiver #(
  parameter int CNT_W    = 11,
  parameter int SYNC_POL = 0,
  parameter int H_OFFSET = 216,
  parameter int H_ACTIVE = 800,
  parameter int V_OFFSET = 27,
  parameter int V_ACTIVE = 600
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hsync_sig,
  input  logic             vsync_sig,
  output logic             locked,
  output logic             lock_lost,
  output logic             ready,
  output logic [CNT_W-1:0] column_addr_sig,
  output logic [CNT_W-1:0] row_addr_sig,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines
);

  // state    | meaning
  // SEARCH   | waiting for the first vsync leading edge
  // MEASURE  | capturing frame height, locks when two full frames agree
  // LOCKED   | timing stable, pixel strobe and addresses generated
  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic             SYNC_ACT = (SYNC_POL != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] H_START  = CNT_W'(H_OFFSET);
  localparam logic [CNT_W-1:0] H_END    = CNT_W'(H_OFFSET + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_START  = CNT_W'(V_OFFSET);
  localparam logic [CNT_W-1:0] V_END    = CNT_W'(V_OFFSET + V_ACTIVE);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_hs_d;
  logic             r_vs_d;
  logic             r_hs_seen;
  logic             r_h_err;
  logic             r_frame_valid;
  logic             r_lock_lost;
  logic             r_ready;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic [CNT_W-1:0] r_line_len;
  logic [CNT_W-1:0] r_frame_lines;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;

  logic             w_hs_lead;
  logic             w_vs_lead;
  logic             w_h_sat;
  logic             w_v_sat;
  logic             w_h_mis;
  logic             w_frame_match;
  logic             w_h_in;
  logic             w_v_in;
  logic             w_pix;
  logic [CNT_W-1:0] w_period;
  logic [CNT_W-1:0] w_new_lines;

  assign w_hs_lead     = (hsync_sig == SYNC_ACT) && (r_hs_d != SYNC_ACT);
  assign w_vs_lead     = (vsync_sig == SYNC_ACT) && (r_vs_d != SYNC_ACT);
  assign w_h_sat       = (r_h_cnt == CNT_MAX);
  assign w_v_sat       = (r_v_cnt == CNT_MAX);
  // A saturated counter stands for a period too long to represent.
  assign w_period      = w_h_sat ? CNT_MAX : r_h_cnt + CNT_W'(1);
  assign w_h_mis       = w_hs_lead && r_hs_seen && (w_period != r_line_len);
  assign w_new_lines   = r_v_cnt + CNT_W'(w_hs_lead);
  assign w_frame_match = (w_new_lines == r_frame_lines);
  assign w_h_in        = (r_h_cnt >= H_START) && (r_h_cnt < H_END);
  assign w_v_in        = (r_v_cnt >= V_START) && (r_v_cnt < V_END);
  assign w_pix         = locked && w_h_in && w_v_in;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SEARCH: begin
        if (w_vs_lead) w_state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (w_vs_lead && r_frame_valid && !r_h_err && !w_h_mis && w_frame_match)
          w_state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (r_h_err || w_h_mis || w_h_sat || (w_vs_lead && !w_frame_match))
          w_state_nxt = ST_SEARCH;
      end
      default: w_state_nxt = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_SEARCH;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hs_d        <= ~SYNC_ACT;
      r_vs_d        <= ~SYNC_ACT;
      r_hs_seen     <= 1'b0;
      r_h_err       <= 1'b0;
      r_frame_valid <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_ready       <= 1'b0;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_line_len    <= '0;
      r_frame_lines <= '0;
      r_col         <= '0;
      r_row         <= '0;
    end else begin
      r_hs_d <= hsync_sig;
      r_vs_d <= vsync_sig;

      if (w_hs_lead)     r_h_cnt <= '0;
      else if (!w_h_sat) r_h_cnt <= r_h_cnt + CNT_W'(1);

      if (w_hs_lead)              r_hs_seen  <= 1'b1;
      if (w_hs_lead && r_hs_seen) r_line_len <= w_period;

      // Clear wins over increment so the line carrying the vsync edge is row 0.
      if (w_vs_lead)                  r_v_cnt <= '0;
      else if (w_hs_lead && !w_v_sat) r_v_cnt <= r_v_cnt + CNT_W'(1);

      if (w_vs_lead) r_frame_lines <= w_new_lines;

      if (r_state == ST_SEARCH) r_frame_valid <= 1'b0;
      else if (w_vs_lead)       r_frame_valid <= 1'b1;

      if (w_vs_lead)    r_h_err <= 1'b0;
      else if (w_h_mis) r_h_err <= 1'b1;

      r_lock_lost <= (r_state == ST_LOCKED) && (w_state_nxt != ST_LOCKED);

      r_ready <= w_pix;
      r_col   <= w_pix ? (r_h_cnt - H_START) : '0;
      r_row   <= w_pix ? (r_v_cnt - V_START) : '0;
    end
  end

  assign locked          = (r_state == ST_LOCKED);
  assign lock_lost       = r_lock_lost;
  assign ready           = r_ready;
  assign column_addr_sig = r_col;
  assign row_addr_sig    = r_row;
  assign line_len        = r_line_len;
  assign frame_lines     = r_frame_lines;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a scaled-down raster (24-clock lines, 10-line frames)
// so that every lock/loss scenario fits in a short run.
module tb_vga_sync_receiver;

  localparam int CNT_W   = 11;
  localparam int LINE    = 24;
  localparam int HS_W    = 3;
  localparam int H_OFF   = 6;
  localparam int H_ACT   = 10;
  localparam int NLINES  = 10;
  localparam int VS_W    = 2;
  localparam int V_OFF   = 3;
  localparam int V_ACT   = 5;
  localparam int PIX     = H_ACT * V_ACT;
  localparam int RST_POS = 12;
  localparam int SAT_CYC = 2049;

  typedef struct {
    int               cyc;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             hsync_sig;
  logic             vsync_sig;
  logic             locked;
  logic             lock_lost;
  logic             ready;
  logic [CNT_W-1:0] column_addr_sig;
  logic [CNT_W-1:0] row_addr_sig;
  logic [CNT_W-1:0] line_len;
  logic [CNT_W-1:0] frame_lines;

  vga_sync_receiver #(
    .CNT_W(CNT_W), .SYNC_POL(0), .H_OFFSET(H_OFF), .H_ACTIVE(H_ACT),
    .V_OFFSET(V_OFF), .V_ACTIVE(V_ACT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync_sig(hsync_sig), .vsync_sig(vsync_sig),
    .locked(locked), .lock_lost(lock_lost), .ready(ready),
    .column_addr_sig(column_addr_sig), .row_addr_sig(row_addr_sig),
    .line_len(line_len), .frame_lines(frame_lines)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    n_checks = 0;
  int    n_errors = 0;
  int    n_ready = 0;
  int    lost_count = 0;
  int    last_lost_cyc = -1;
  int    rise_cyc = -1;
  int    g_hs_cyc = 0;
  int    g_vs_cyc = 0;
  int    g_long_next_cyc = 0;
  logic  prev_locked = 1'b0;
  logic  g_rst_pending = 1'b0;
  logic [4*CNT_W+2:0] g_snap;
  exp_t  sb_q[$];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d, required completion", cyc);
    $fatal(1);
  end

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ready === 1'b1) begin
        n_ready++;
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_ready: cycle %0d col %0d row %0d, required ready=0", cyc, column_addr_sig, row_addr_sig);
        end else begin
          e = sb_q.pop_front();
          if (cyc !== e.cyc || column_addr_sig !== e.col || row_addr_sig !== e.row) begin
            n_errors++;
            $display("FAIL pixel: got cycle %0d col %0d row %0d, required cycle %0d col %0d row %0d",
                     cyc, column_addr_sig, row_addr_sig, e.cyc, e.col, e.row);
          end
        end
      end else if (cyc > 0) begin
        n_checks++;
        if (column_addr_sig !== '0 || row_addr_sig !== '0) begin
          n_errors++;
          $display("FAIL idle_addr: cycle %0d col %0d row %0d, required 0 0", cyc, column_addr_sig, row_addr_sig);
        end
      end
      if (lock_lost === 1'b1) begin
        lost_count++;
        last_lost_cyc = cyc;
      end
      if (locked === 1'b1 && prev_locked === 1'b0) rise_cyc = cyc;
      prev_locked = locked;
    end
  endtask

  // Drives one frame; lines below exp_lines push their active pixels to the scoreboard.
  task automatic send_frame(input int nlines, input int exp_lines, input int long_line,
                            input int vs_off, input int rst_line);
    int len;
    int ncol;
    exp_t e;
    for (int l = 0; l < nlines; l++) begin
      len = (l == long_line) ? LINE + 1 : LINE;
      for (int p = 0; p < len; p++) begin
        @(posedge clk);
        #1;
        if (g_rst_pending) begin
          g_snap = {locked, lock_lost, ready, column_addr_sig, row_addr_sig, line_len, frame_lines};
          rst_n = 1'b1;
          g_rst_pending = 1'b0;
        end
        hsync_sig = (p < HS_W) ? 1'b0 : 1'b1;
        vsync_sig = ((l > 0 || p >= vs_off) && (l < VS_W || (l == VS_W && p < vs_off))) ? 1'b0 : 1'b1;
        if (l == 0 && p == vs_off) g_vs_cyc = cyc;
        if (l == rst_line && p == RST_POS) begin
          rst_n = 1'b0;
          g_rst_pending = 1'b1;
        end
        if (p == 0) begin
          g_hs_cyc = cyc;
          if (l == long_line + 1) g_long_next_cyc = cyc;
          if (l >= V_OFF && l < V_OFF + V_ACT) begin
            // On the reset line only pixels shown before the reset edge survive.
            ncol = (l < exp_lines) ? H_ACT : (l == rst_line) ? RST_POS - H_OFF - 1 : 0;
            for (int m = 0; m < ncol; m++) begin
              e.cyc = cyc + 2 + H_OFF + m;
              e.col = CNT_W'(m);
              e.row = CNT_W'(l - V_OFF);
              sb_q.push_back(e);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hsync_sig = 1'b1;
    vsync_sig = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({locked, lock_lost, ready} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags: got locked/lost/ready %b, required 000", {locked, lock_lost, ready});
    end
    n_checks++;
    if ({column_addr_sig, row_addr_sig} !== '0) begin
      n_errors++;
      $display("FAIL reset_addr: got col %0d row %0d, required 0 0", column_addr_sig, row_addr_sig);
    end
    n_checks++;
    if ({line_len, frame_lines} !== '0) begin
      n_errors++;
      $display("FAIL reset_meas: got line_len %0d frame_lines %0d, required 0 0", line_len, frame_lines);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (locked !== 1'b0 || line_len !== '0) begin
      n_errors++;
      $display("FAIL post_reset_idle: got locked %b line_len %0d, required 0 0", locked, line_len);
    end
  endtask

  task automatic test_lock();
    int r0 = n_ready;
    send_frame(NLINES, 0, -1, 0, -1);
    send_frame(NLINES, 0, -1, 0, -1);
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++;
      $display("FAIL early_lock: got locked %b after 2 vsync edges, required 0", locked);
    end
    n_checks++;
    if (line_len !== CNT_W'(LINE)) begin
      n_errors++;
      $display("FAIL line_len: got %0d, required %0d", line_len, LINE);
    end
    n_checks++;
    if (frame_lines !== CNT_W'(NLINES)) begin
      n_errors++;
      $display("FAIL frame_lines: got %0d, required %0d", frame_lines, NLINES);
    end
    send_frame(NLINES, NLINES, -1, 0, -1);
    n_checks++;
    if (rise_cyc !== g_vs_cyc + 1 || locked !== 1'b1) begin
      n_errors++;
      $display("FAIL lock_rise: got locked %b rising at cycle %0d, required 1 at %0d", locked, rise_cyc, g_vs_cyc + 1);
    end
    n_checks++;
    if (n_ready - r0 !== PIX || sb_q.size() !== 0) begin
      n_errors++;
      $display("FAIL lock_pixels: got %0d ready cycles (%0d missing), required %0d", n_ready - r0, sb_q.size(), PIX);
    end
  endtask

  task automatic test_vsync_offset();
    int r0 = n_ready;
    int l0 = lost_count;
    send_frame(NLINES, NLINES, -1, 5, -1);
    send_frame(NLINES, NLINES, -1, 0, -1);
    n_checks++;
    if (locked !== 1'b1 || lost_count !== l0) begin
      n_errors++;
      $display("FAIL vs_offset_lock: got locked %b lost pulses %0d, required 1 0", locked, lost_count - l0);
    end
    n_checks++;
    if (n_ready - r0 !== 2 * PIX || sb_q.size() !== 0) begin
      n_errors++;
      $display("FAIL vs_offset_pixels: got %0d ready cycles, required %0d", n_ready - r0, 2 * PIX);
    end
  endtask

  task automatic test_long_line();
    int r0 = n_ready;
    int l0 = lost_count;
    send_frame(NLINES, 6, 5, 0, -1);
    n_checks++;
    if (lost_count !== l0 + 1 || last_lost_cyc !== g_long_next_cyc + 1) begin
      n_errors++;
      $display("FAIL long_line_lost: got %0d pulses last at cycle %0d, required 1 at %0d",
               lost_count - l0, last_lost_cyc, g_long_next_cyc + 1);
    end
    n_checks++;
    if (locked !== 1'b0 || line_len !== CNT_W'(LINE) || n_ready - r0 !== 3 * H_ACT) begin
      n_errors++;
      $display("FAIL long_line_state: got locked %b line_len %0d ready %0d, required 0 %0d %0d",
               locked, line_len, n_ready - r0, LINE, 3 * H_ACT);
    end
    send_frame(NLINES, 0, -1, 0, -1);
    send_frame(NLINES, 0, -1, 0, -1);
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++;
      $display("FAIL long_line_early: got locked %b after 2 further vsync edges, required 0", locked);
    end
    send_frame(NLINES, NLINES, -1, 0, -1);
    n_checks++;
    if (locked !== 1'b1 || rise_cyc !== g_vs_cyc + 1 || sb_q.size() !== 0) begin
      n_errors++;
      $display("FAIL long_line_relock: got locked %b rise %0d pending %0d, required 1 %0d 0",
               locked, rise_cyc, sb_q.size(), g_vs_cyc + 1);
    end
  endtask

  task automatic test_short_frame();
    int l0 = lost_count;
    send_frame(NLINES - 1, NLINES, -1, 0, -1);
    send_frame(NLINES, 0, -1, 0, -1);
    n_checks++;
    if (lost_count !== l0 + 1 || last_lost_cyc !== g_vs_cyc + 1) begin
      n_errors++;
      $display("FAIL short_frame_lost: got %0d pulses last at cycle %0d, required 1 at %0d",
               lost_count - l0, last_lost_cyc, g_vs_cyc + 1);
    end
    n_checks++;
    if (frame_lines !== CNT_W'(NLINES - 1) || locked !== 1'b0) begin
      n_errors++;
      $display("FAIL short_frame_state: got frame_lines %0d locked %b, required %0d 0", frame_lines, locked, NLINES - 1);
    end
    send_frame(NLINES, 0, -1, 0, -1);
    send_frame(NLINES, 0, -1, 0, -1);
    send_frame(NLINES, NLINES, -1, 0, -1);
    n_checks++;
    if (locked !== 1'b1 || rise_cyc !== g_vs_cyc + 1 || frame_lines !== CNT_W'(NLINES)) begin
      n_errors++;
      $display("FAIL short_frame_relock: got locked %b rise %0d frame_lines %0d, required 1 %0d %0d",
               locked, rise_cyc, frame_lines, g_vs_cyc + 1, NLINES);
    end
  endtask

  task automatic test_hsync_loss();
    int l0 = lost_count;
    int hs0 = g_hs_cyc;
    repeat (2100) begin
      @(posedge clk);
      #1;
      hsync_sig = 1'b1;
      vsync_sig = 1'b1;
    end
    n_checks++;
    if (lost_count !== l0 + 1 || last_lost_cyc !== hs0 + SAT_CYC) begin
      n_errors++;
      $display("FAIL hsync_loss_lost: got %0d pulses last at cycle %0d, required 1 at %0d",
               lost_count - l0, last_lost_cyc, hs0 + SAT_CYC);
    end
    n_checks++;
    if ({locked, ready, column_addr_sig, row_addr_sig} !== '0) begin
      n_errors++;
      $display("FAIL hsync_loss_outputs: got locked %b ready %b col %0d row %0d, required all 0",
               locked, ready, column_addr_sig, row_addr_sig);
    end
    send_frame(NLINES, 0, -1, 0, -1);
    send_frame(NLINES, 0, -1, 0, -1);
    send_frame(NLINES, NLINES, -1, 0, -1);
    n_checks++;
    if (locked !== 1'b1 || rise_cyc !== g_vs_cyc + 1) begin
      n_errors++;
      $display("FAIL hsync_loss_relock: got locked %b rise %0d, required 1 %0d", locked, rise_cyc, g_vs_cyc + 1);
    end
  endtask

  task automatic test_reset_midline();
    int r0 = n_ready;
    int l0 = lost_count;
    send_frame(NLINES, 4, -1, 0, 4);
    n_checks++;
    if (g_snap !== '0) begin
      n_errors++;
      $display("FAIL midline_reset_outputs: got %h, required 0", g_snap);
    end
    n_checks++;
    if (lost_count !== l0 || locked !== 1'b0 || n_ready - r0 !== H_ACT + RST_POS - H_OFF - 1) begin
      n_errors++;
      $display("FAIL midline_reset_state: got lost %0d locked %b ready %0d, required 0 0 %0d",
               lost_count - l0, locked, n_ready - r0, H_ACT + RST_POS - H_OFF - 1);
    end
    send_frame(NLINES, 0, -1, 0, -1);
    send_frame(NLINES, 0, -1, 0, -1);
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++;
      $display("FAIL midline_reset_early: got locked %b after 2 vsync edges, required 0", locked);
    end
    send_frame(NLINES, NLINES, -1, 0, -1);
    n_checks++;
    if (locked !== 1'b1 || rise_cyc !== g_vs_cyc + 1 || sb_q.size() !== 0) begin
      n_errors++;
      $display("FAIL midline_reset_relock: got locked %b rise %0d pending %0d, required 1 %0d 0",
               locked, rise_cyc, sb_q.size(), g_vs_cyc + 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    hsync_sig = 1'b1;
    vsync_sig = 1'b1;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_lock();
    test_vsync_offset();
    test_long_line();
    test_short_frame();
    test_hsync_loss();
    test_reset_midline();
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
